integral_image_builder: RTL
===========================

# integral_image_builder

Streams a WIDTH×WIDTH frame of grey-level pixels in row-major order, builds its integral image, and publishes it as the flat `image` bus plus `image_valid` feeding `top_level_classifier` (`image`, `en`). Sits directly upstream of the classifier. It double-buffers: the next frame is accumulated while the classifier evaluates the published one, and publication is gated by the classifier's `request_new_data`.

## Interface
- `WIDTH`, 20, frame side length in pixels; frame = WIDTH*WIDTH pixels.
- `BITSIZE`, 9, width of each integral-image entry.
- `PIXEL_BITS`, 8, width of an input pixel.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pixel`  in  PIXEL_BITS  input pixel, unsigned.
- `pixel_valid`  in  1  `pixel` is valid this cycle.
- `pixel_sof`  in  1  qualifies `pixel` as row 0, column 0 of a frame.
- `pixel_ready`  out  1  block accepts a pixel this cycle.
- `request_new_data`  in  1  classifier has consumed the published image.
- `image`  out  WIDTH*WIDTH*BITSIZE  published integral image; entry (r,c) at bits `[(r*WIDTH+c)*BITSIZE +: BITSIZE]`.
- `image_valid`  out  1  `image` holds an unconsumed frame; drives classifier `en`.

## Operation
- Accept = `pixel_valid && pixel_ready` at a rising edge. Pixel index idx = r*WIDTH+c, advancing 0..WIDTH²−1.
- ii(r,c) = row_sum(r,c) + ii(r−1,c), with row_sum(r,c) = the sum of p(r,0..c); ii(−1,c)=0. row_sum clears at c=0.
- Arithmetic is modulo 2^BITSIZE: wrap, never saturate. Pixel zero-extends. Rectangle differences stay exact as long as the true rectangle sum is < 2^BITSIZE.
- Working buffer: WIDTH² × BITSIZE registers. ii(r−1,c) is read from entry idx−WIDTH.
- States:
  - FILL: `pixel_ready`=1. On accept, write entry idx and advance. On accepting idx = WIDTH²−1, go to DONE.
  - DONE: `pixel_ready`=0. When the slot is free, copy the working buffer to `image`, set `image_valid`=1, clear idx and row_sum, and return to FILL. Otherwise hold.
- slot free = `!image_valid || request_new_data`.
- Consumption: in any cycle with `image_valid && request_new_data` and no copy that cycle, `image_valid` goes to 0. If a copy and consumption coincide, the copy wins and `image_valid` stays 1. `request_new_data` while `image_valid`=0 is ignored.
- Resync: an accepted pixel with `pixel_sof`=1 is always stored as idx 0. The partial frame is discarded and row_sum restarts. `pixel_sof` at idx 0 is a no-op. A missing sof does not stall.
- `image` changes only on a copy edge and is stable otherwise.

## Timing
- Reset values: `image`=0, `image_valid`=0, state FILL, idx=0, row_sum=0, so `pixel_ready`=1 (combinational from state). Working buffer contents are don't-care.
- Reset mid-frame or mid-publish: everything returns to reset values immediately; the partial frame is lost.
- Throughput: 1 pixel/cycle in FILL, with no bubble between rows.
- Latency: if the last pixel is accepted at edge E and the slot is free, the copy happens at E+1. `image_valid` is high and `pixel_ready` is high again after E+1. Minimum frame period is WIDTH²+1 cycles.
- If the slot is busy, the block holds DONE. The copy occurs at the first edge that samples `request_new_data`=1.

## Structure
- Shared package `classifier_pkg`: `WIDTH`, `BITSIZE` defaults, the `PIXEL_BITS` default, and an entry-offset function idx→bit offset shared with the classifier.
- One sub-module `integral_row_unit` (combinational): from pixel, row_sum, and ii_above, it produces the new row_sum and ii, both modulo 2^BITSIZE.
- The FSM, index counter and both buffers live in the top.

## Test plan
- Constant pixel 1, `request_new_data` tied 0 → after 400 accepts, `image_valid` rises 1 cycle later, entry (r,c) = (r+1)(c+1), entry (19,19) = 400, `image` bits [8:0] = 1.
- Constant pixel 2 → entry (19,19) = 800 mod 512 = 288 (wrap), entry (0,0) = 2, entry (0,19) = 40.
- Two frames back-to-back with `request_new_data`=0 → second frame holds `pixel_ready`=0 at idx 399. A one-cycle `request_new_data` pulse triggers the copy on that edge, `image_valid` stays 1, and `image` switches to frame 2.
- `request_new_data` pulse with no frame pending → `image_valid` drops to 0 the next cycle and `image` is unchanged.
- `pixel_sof` asserted at idx 137 followed by a full 400-pixel frame → output equals a clean single-frame reference, with no contribution from the first 137 pixels.
- `rst` asserted at idx 250 and while `image_valid`=1 → `image`=0, `image_valid`=0, `pixel_ready`=1 asynchronously. The next full frame publishes correctly.

Source files
------------

// File: rtl/classifier_pkg.sv
// ---------------------------------------------------------------------------
// classifier_pkg: frame geometry defaults, builder state encoding and the
// entry-offset helper shared by the integral-image builder and the classifier.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package classifier_pkg;

  localparam int DEF_WIDTH      = 20;
  localparam int DEF_BITSIZE    = 9;
  localparam int DEF_PIXEL_BITS = 8;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } build_state_t;

  // Bit offset of flat-index entry idx within the packed image bus.
  function automatic int unsigned entry_offset(input int unsigned idx,
                                               input int unsigned bits);
    return idx * bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/integral_image_builder_if.sv
// ---------------------------------------------------------------------------
// integral_image_builder_if: pixel stream in, published integral image out.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface integral_image_builder_if
  import classifier_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BITSIZE    = DEF_BITSIZE,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS
);

  logic [PIXEL_BITS-1:0]            pixel;
  logic                             pixel_valid;
  logic                             pixel_sof;
  logic                             pixel_ready;
  logic                             request_new_data;
  logic [WIDTH*WIDTH*BITSIZE-1:0]   image;
  logic                             image_valid;

  modport master (
    output pixel, pixel_valid, pixel_sof, request_new_data,
    input  pixel_ready, image, image_valid
  );

  modport slave (
    input  pixel, pixel_valid, pixel_sof, request_new_data,
    output pixel_ready, image, image_valid
  );

endinterface

`default_nettype wire

// File: rtl/integral_row_unit.sv
// ---------------------------------------------------------------------------
// integral_row_unit: one integral-image step, row_sum += pixel, ii = row_sum
// + ii_above, all modulo 2^BITSIZE.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module integral_row_unit
  import classifier_pkg::*;
#(
  parameter int BITSIZE    = DEF_BITSIZE,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS
) (
  input  wire logic [PIXEL_BITS-1:0] pixel,
  input  wire logic [BITSIZE-1:0]    row_sum_in,
  input  wire logic [BITSIZE-1:0]    ii_above,
  output logic      [BITSIZE-1:0]    row_sum_out,
  output logic      [BITSIZE-1:0]    ii_out
);

  // Unsigned cast zero-extends (or truncates) the pixel; sums wrap naturally.
  assign row_sum_out = row_sum_in + BITSIZE'(pixel);
  assign ii_out      = row_sum_out + ii_above;

endmodule

`default_nettype wire

// File: rtl/integral_image_builder.sv
// ---------------------------------------------------------------------------
// integral_image_builder: accumulates a WIDTH x WIDTH frame into a working
// integral image and copies it to the published image when the slot frees.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module integral_image_builder
  import classifier_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BITSIZE    = DEF_BITSIZE,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS
) (
  input wire logic                clk,
  input wire logic                rst,
  integral_image_builder_if.slave bus
);

  localparam int NPIX  = WIDTH * WIDTH;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  build_state_t              state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [BITSIZE-1:0]        row_sum_q, row_sum_d;
  logic [NPIX*BITSIZE-1:0]   image_q, image_d;
  logic                      image_valid_q, image_valid_d;

  logic [BITSIZE-1:0]        work_q [NPIX];
  logic [NPIX*BITSIZE-1:0]   work_flat;

  logic                      accept;
  logic                      slot_free;
  logic                      copy;
  logic [IDX_W-1:0]          eff_idx;
  logic [COL_W-1:0]          eff_col;
  logic [BITSIZE-1:0]        row_sum_in;
  logic [BITSIZE-1:0]        ii_above;
  logic [BITSIZE-1:0]        row_sum_new;
  logic [BITSIZE-1:0]        ii_new;

  logic                      wr_en;
  logic [IDX_W-1:0]          wr_addr;
  logic [BITSIZE-1:0]        wr_data;

  assign bus.pixel_ready = (state_q == ST_FILL);
  assign bus.image       = image_q;
  assign bus.image_valid = image_valid_q;

  assign accept    = (state_q == ST_FILL) && bus.pixel_valid;
  assign slot_free = !image_valid_q || bus.request_new_data;
  assign copy      = (state_q == ST_DONE) && slot_free;

  // A start-of-frame pixel forces position (0,0) and drops any partial frame.
  assign eff_idx    = bus.pixel_sof ? '0 : idx_q;
  assign eff_col    = bus.pixel_sof ? '0 : col_q;
  assign row_sum_in = (eff_col == '0) ? '0 : row_sum_q;
  assign ii_above   = (eff_idx < ROW_STEP) ? '0 : work_q[eff_idx - ROW_STEP];

  integral_row_unit #(
    .BITSIZE    (BITSIZE),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_row_unit (
    .pixel       (bus.pixel),
    .row_sum_in  (row_sum_in),
    .ii_above    (ii_above),
    .row_sum_out (row_sum_new),
    .ii_out      (ii_new)
  );

  for (genvar gi = 0; gi < NPIX; gi++) begin : g_pack
    assign work_flat[entry_offset(gi, BITSIZE) +: BITSIZE] = work_q[gi];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    col_d         = col_q;
    row_sum_d     = row_sum_q;
    image_d       = image_q;
    image_valid_d = image_valid_q;
    wr_en         = 1'b0;
    wr_addr       = eff_idx;
    wr_data       = ii_new;

    if (accept) begin
      wr_en     = 1'b1;
      idx_d     = eff_idx + 1'b1;
      col_d     = (eff_col == LAST_COL) ? '0 : eff_col + 1'b1;
      row_sum_d = row_sum_new;
      if (eff_idx == LAST_IDX) begin
        state_d = ST_DONE;
      end
    end

    // A copy outranks a simultaneous consumption: the new frame stays valid.
    if (copy) begin
      image_d       = work_flat;
      image_valid_d = 1'b1;
      idx_d         = '0;
      col_d         = '0;
      row_sum_d     = '0;
      state_d       = ST_FILL;
    end else if (image_valid_q && bus.request_new_data) begin
      image_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FILL;
      idx_q         <= '0;
      col_q         <= '0;
      row_sum_q     <= '0;
      image_q       <= '0;
      image_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      col_q         <= col_d;
      row_sum_q     <= row_sum_d;
      image_q       <= image_d;
      image_valid_q <= image_valid_d;
    end
  end

  // Working buffer has no reset; stale entries are never read before rewrite.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      work_q[wr_addr] <= wr_data;
    end
  end

endmodule

`default_nettype wire
